// File: rtl/manhattan_ring_gen.sv
// rtl/manhattan_ring_gen.sv - streams all grid points at a given Manhattan radius from a centre
module manhattan_ring_gen #(
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [COORD_W-1:0] radius,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               busy,
    output logic               done,
    output logic [COORD_W+1:0] count
);
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] MAX_C = SW'((1 << COORD_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [COORD_W-1:0]        cx_q, cx_d, cy_q, cy_d, r_q, r_d;
    logic signed [SW-1:0]      dx_q, dx_d;
    logic                      neg_q, neg_d;
    logic                      out_valid_q, out_valid_d;
    logic [COORD_W-1:0]        out_x_q, out_x_d, out_y_q, out_y_d;
    logic [COORD_W+1:0]        count_q, count_d;

    logic                      advance, last, load;
    logic signed [SW-1:0]      mag_q, mag_n, x_n, y_n;

    function automatic logic signed [SW-1:0] ext(input logic [COORD_W-1:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic signed [SW-1:0] abs_s(input logic signed [SW-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            r_q         <= '0;
            dx_q        <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            r_q         <= r_d;
            dx_q        <= dx_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            count_q     <= count_d;
        end
    end

    // A candidate resolves when it is either skipped (not valid) or handed over.
    assign advance = !out_valid_q || out_ready;
    assign last    = (dx_q == ext(r_q));
    assign mag_q   = ext(r_q) - abs_s(dx_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (advance && last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cx_d        = cx_q;
        cy_d        = cy_q;
        r_d         = r_q;
        dx_d        = dx_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        count_d     = count_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    r_d     = radius;
                    dx_d    = -ext(radius);
                    neg_d   = 1'b0;
                    count_d = '0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (advance) begin
                    if (out_valid_q) count_d = count_q + (COORD_W+2)'(1);
                    if (last) begin
                        out_valid_d = 1'b0;
                    end else begin
                        if (!neg_q && mag_q != 0) begin
                            neg_d = 1'b1;
                        end else begin
                            dx_d  = dx_q + SW'(1);
                            neg_d = 1'b0;
                        end
                        load = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Evaluate the candidate the iterator will point at after this edge.
        mag_n = ext(r_d) - abs_s(dx_d);
        x_n   = ext(cx_d) + dx_d;
        y_n   = neg_d ? (ext(cy_d) - mag_n) : (ext(cy_d) + mag_n);
        if (load) begin
            out_valid_d = (x_n >= 0) && (x_n <= MAX_C) && (y_n >= 0) && (y_n <= MAX_C);
            if (out_valid_d) begin
                out_x_d = x_n[COORD_W-1:0];
                out_y_d = y_n[COORD_W-1:0];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign count     = count_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
endmodule
